// File: rtl/div_rs_pkg.sv
// Shared types for the divide reservation station: entry layout and CDB wake-up helper.
package div_rs_pkg;

    localparam int COMMANDS_W = 10;
    localparam int DATA_W     = 64;
    localparam int ROB_SIZE   = 32;
    localparam int TAG_W      = $clog2(ROB_SIZE + 1);

    typedef struct packed {
        logic              rdy;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] val;
    } rs_src_t;

    typedef struct packed {
        logic                  valid;
        logic [COMMANDS_W-1:0] commands;
        logic [TAG_W-1:0]      tag;
        rs_src_t               src1;
        rs_src_t               src2;
    } rs_entry_t;

    // A waiting source captures the broadcast value when its producer tag is on the CDB.
    function automatic rs_src_t wake_src(input rs_src_t s, input logic cdb_v,
                                         input logic [TAG_W-1:0] cdb_tag,
                                         input logic [DATA_W-1:0] cdb_val);
        rs_src_t r;
        r = s;
        if (!s.rdy && cdb_v && (s.tag == cdb_tag)) begin
            r.rdy = 1'b1;
            r.val = cdb_val;
        end
        return r;
    endfunction

endpackage

// File: rtl/rs_oldest_ready_select.sv
// Priority encoder picking the lowest-index (oldest) ready slot.
module rs_oldest_ready_select #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_ready,
    output logic [N-1:0]     o_onehot,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    // Scan from the top down so the lowest ready index is the last one written.
    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_any    = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_ready[i]) begin
                o_onehot    = '0;
                o_onehot[i] = 1'b1;
                o_idx       = IDX_W'(i);
                o_any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/div_reservation_station.sv
// Age-ordered collapsing reservation station for the divide unit with CDB snooping
// and readyRS/stallRS issue handshake.
module div_reservation_station
    import div_rs_pkg::*;
#(
    parameter int ROBsize    = 32,
    parameter int ROBsizeLog = $clog2(ROBsize + 1),
    parameter int DEPTH      = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  flush_i,
    input  logic                  dispatchValid_i,
    input  logic [COMMANDS_W-1:0] dispatchCommands_i,
    input  logic [ROBsizeLog-1:0] dispatchTag_i,
    input  logic [63:0]           src1Val_i,
    input  logic [63:0]           src2Val_i,
    input  logic                  src1Rdy_i,
    input  logic                  src2Rdy_i,
    input  logic [ROBsizeLog-1:0] src1Tag_i,
    input  logic [ROBsizeLog-1:0] src2Tag_i,
    output logic                  full_o,
    input  logic                  cdbValid_i,
    input  logic [ROBsizeLog-1:0] cdbTag_i,
    input  logic [63:0]           cdbVal_i,
    output logic                  readyRS_o,
    input  logic                  stallRS_i,
    output logic [63:0]           reservationStationVal1_o,
    output logic [63:0]           reservationStationVal2_o,
    output logic [COMMANDS_W-1:0] reservationStationCommands_o,
    output logic [ROBsizeLog-1:0] reservationStationTag_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    rs_entry_t        r_ent [DEPTH];
    logic [CNT_W-1:0] r_count;
    logic             r_full;

    logic [DEPTH-1:0] w_ready;
    logic [DEPTH-1:0] w_sel_onehot;
    logic [IDX_W-1:0] w_sel_idx;
    logic             w_any;
    logic             w_issue;
    logic             w_disp;
    logic [CNT_W-1:0] w_wr_slot;
    logic [CNT_W-1:0] w_count_next;
    rs_entry_t        w_new;
    rs_entry_t        w_woken [DEPTH];
    rs_entry_t        w_above [DEPTH];
    rs_entry_t        w_next  [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        assign w_ready[g] = r_ent[g].valid & r_ent[g].src1.rdy & r_ent[g].src2.rdy;

        always_comb begin
            w_woken[g]      = r_ent[g];
            w_woken[g].src1 = wake_src(r_ent[g].src1, cdbValid_i, cdbTag_i, cdbVal_i);
            w_woken[g].src2 = wake_src(r_ent[g].src2, cdbValid_i, cdbTag_i, cdbVal_i);
        end

        // Source for a slot when the queue collapses over an issued entry.
        if (g < DEPTH - 1) begin : g_shift
            assign w_above[g] = w_woken[g+1];
        end else begin : g_top
            assign w_above[g] = '0;
        end
    end

    rs_oldest_ready_select #(.N(DEPTH), .IDX_W(IDX_W)) u_select (
        .i_ready  (w_ready),
        .o_onehot (w_sel_onehot),
        .o_idx    (w_sel_idx),
        .o_any    (w_any)
    );

    assign readyRS_o = w_any;
    assign full_o    = r_full;
    assign w_issue   = w_any & ~stallRS_i;
    assign w_disp    = dispatchValid_i & ~r_full & ~flush_i;
    assign w_wr_slot = r_count - CNT_W'(w_issue);

    always_comb begin
        reservationStationVal1_o     = '0;
        reservationStationVal2_o     = '0;
        reservationStationCommands_o = '0;
        reservationStationTag_o      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_sel_onehot[i]) begin
                reservationStationVal1_o     |= r_ent[i].src1.val;
                reservationStationVal2_o     |= r_ent[i].src2.val;
                reservationStationCommands_o |= r_ent[i].commands;
                reservationStationTag_o      |= r_ent[i].tag;
            end
        end
    end

    // New entry may already be woken by a broadcast in its own dispatch cycle.
    always_comb begin
        w_new          = '0;
        w_new.valid    = 1'b1;
        w_new.commands = dispatchCommands_i;
        w_new.tag      = dispatchTag_i;
        w_new.src1     = wake_src('{rdy: src1Rdy_i, tag: src1Tag_i, val: src1Val_i},
                                  cdbValid_i, cdbTag_i, cdbVal_i);
        w_new.src2     = wake_src('{rdy: src2Rdy_i, tag: src2Tag_i, val: src2Val_i},
                                  cdbValid_i, cdbTag_i, cdbVal_i);
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            if (w_issue && (i >= int'(w_sel_idx))) begin
                w_next[i] = w_above[i];
            end else begin
                w_next[i] = w_woken[i];
            end
            if (w_disp && (CNT_W'(i) == w_wr_slot)) begin
                w_next[i] = w_new;
            end
        end
    end

    assign w_count_next = r_count + CNT_W'(w_disp) - CNT_W'(w_issue);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
        end else if (flush_i) begin
            for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) r_ent[i] <= w_next[i];
            r_count <= w_count_next;
            r_full  <= (w_count_next == CNT_W'(DEPTH));
        end
    end

endmodule

// File: doc/div_reservation_station.md
Name: div_reservation_station

Overview:
- Reservation station feeding the divide issue/execute stage.
- Holds up to DEPTH dispatched divide instructions and snoops the common data bus (CDB) for pending source operands.
- Presents the oldest fully-ready entry to the divide stage using the readyRS/stallRS handshake.
- Entries are kept in age order in a collapsing queue; slot 0 is the oldest.

Parameters:
- ROBsize, 32, number of ROB entries; sets tag width.
- ROBsizeLog, $clog2(ROBsize+1), tag width in bits.
- DEPTH, 4, number of station entries (2..8).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-high reset.
- flush_i  in  1  synchronous squash of all entries.
- dispatchValid_i  in  1  dispatch request.
- dispatchCommands_i  in  10  control bits for the instruction.
- dispatchTag_i  in  ROBsizeLog  ROB tag of the instruction.
- src1Val_i, src2Val_i  in  64 each  operand values (dividend, divisor).
- src1Rdy_i, src2Rdy_i  in  1 each  operand value is valid.
- src1Tag_i, src2Tag_i  in  ROBsizeLog each  producer tag when the operand is not ready.
- full_o  out  1  station full; dispatch is refused.
- cdbValid_i  in  1  CDB broadcast valid.
- cdbTag_i  in  ROBsizeLog  CDB producer tag.
- cdbVal_i  in  64  CDB value.
- readyRS_o  out  1  an issue candidate is presented.
- stallRS_i  in  1  divide stage cannot accept this cycle.
- reservationStationVal1_o, reservationStationVal2_o  out  64 each  operands of the candidate.
- reservationStationCommands_o  out  10  commands of the candidate.
- reservationStationTag_o  out  ROBsizeLog  tag of the candidate.

Behaviour:
- Reset (async, reset_i=1): all entry valid bits cleared, count=0. full_o=0, readyRS_o=0, all data outputs 0. Reset mid-operation discards every entry; nothing is issued afterwards.
- Entry state: valid, commands, tag, and per source {rdy, tag, val}.
- Dispatch:
  - Accepted when dispatchValid_i & ~full_o & ~flush_i.
  - Written at the clock edge into slot (count - issuedThisCycle).
  - full_o is registered and equals (count==DEPTH). A slot freed by an issue in the full cycle is not reusable until the next cycle.
- Dispatch bypass: if a source is not ready and cdbValid_i with cdbTag_i==srcTag in the same cycle, the entry is written with rdy=1 and val=cdbVal_i.
- Wake-up:
  - Every valid entry with a not-ready source whose tag matches a valid CDB sets rdy=1 and val=cdbVal_i at the edge.
  - This includes entries that shift in the same cycle; the shifted copy carries the captured value.
  - Both sources of one entry may wake from the same broadcast.
- Issue select (combinational from registered state):
  - Candidate is the lowest-index valid entry with both rdy=1.
  - readyRS_o=1 iff a candidate exists. Outputs show the candidate, or zeros when there is none.
  - An entry woken this cycle is eligible the next cycle (1-cycle wake-to-issue minimum).
- Issue handshake:
  - Issue fires on readyRS_o & ~stallRS_i; the entry is removed at that edge.
  - Entries above the removed slot shift down one place, preserving age order.
  - While stallRS_i=1 the outputs hold. The candidate may change only if an older entry becomes ready.
  - The divide stage lowers stall for exactly one cycle per accept.
- Simultaneous events:
  - Issue plus dispatch: count is unchanged and the new entry lands at the top valid slot.
  - Issue plus CDB: the CDB is applied to the surviving entries.
- Flush: at the next edge all entries are invalidated and count=0. Flush has priority over dispatch, issue and wake-up. readyRS_o is not gated by flush during the flush cycle.
- Arithmetic: count is $clog2(DEPTH+1) bits. There is no tag wrap handling; tags are unique while in flight.

Decomposition:
- Shared package div_rs_pkg: the rs_entry_t struct (valid, commands[9:0], tag, src1/src2 {rdy, tag, val[63:0]}) and the COMMANDS_W=10 constant.
- One sub-module: rs_oldest_ready_select, a parameterised priority encoder returning a one-hot and an index of the lowest ready slot plus an any-ready flag.

Test Plan:
- Basic issue:
  - After reset, dispatch {15, 3, rdy both, cmd 10, tag 3}.
  - Next cycle readyRS_o=1 with Val1=15, Val2=3, Commands=10, Tag=3.
  - stallRS_i=0 issues it; readyRS_o=0 the following cycle.
- CDB wake-up:
  - Dispatch tag 5 with src2 waiting on tag 7.
  - CDB {7, 4} two cycles later; readyRS_o rises the cycle after the CDB, with Val2=4.
  - Dispatch-cycle CDB with tag 7 instead makes the entry issuable the next cycle.
- Age order:
  - Dispatch tags 1 (waiting), 2 (ready), 3 (ready).
  - Tag 2 issues, then tag 3.
  - After tag 1 wakes it issues next, and the queue compacts correctly.
- Full and stall:
  - Fill 4 entries with stallRS_i=1; full_o=1 and a 5th dispatch is ignored.
  - Outputs hold steady for 5 stall cycles.
  - Release stall for one cycle: full_o=0 next cycle.
- Simultaneous issue, dispatch and CDB:
  - Count stays 3.
  - The waiting shifted entry captures the CDB value.
  - The new entry sits at slot 2.
- Flush and async reset:
  - flush_i with 3 entries gives count=0 and readyRS_o=0 next cycle.
  - reset_i asserted between clock edges clears outputs immediately, without waiting for a clock edge.
